// File: rtl/nicnac16_pkg.sv
// Shared types and helpers for the 16-bit one-hot select/distribute pair.
package nicnac16_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned NUM_SLOTS = 4;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } sel_enc_t;

    // Lowest-lettered asserted select wins; idx is don't-care when hit is low.
    function automatic sel_enc_t prio_enc(input logic [3:0] sel);
        sel_enc_t r;
        r.hit = |sel;
        if (sel[0])      r.idx = SLOT_A;
        else if (sel[1]) r.idx = SLOT_B;
        else if (sel[2]) r.idx = SLOT_C;
        else             r.idx = SLOT_D;
        return r;
    endfunction

endpackage

// File: rtl/dist_slot.sv
// Single-entry holding register with push/pop handshake; push beats pop.
module dist_slot #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (push_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/distribute1to4_16.sv
// Routes one source beat to one of four registered slots by priority one-hot select.
// Optional select-error flag built when DISTRIBUTE1TO4_16_SELERR_EN is defined.
module distribute1to4_16
    import nicnac16_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] IN,
    input  logic             IN_VALID,
    input  logic             SEL_A,
    input  logic             SEL_B,
    input  logic             SEL_C,
    input  logic             SEL_D,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT_A,
    output logic [WIDTH-1:0] OUT_B,
    output logic [WIDTH-1:0] OUT_C,
    output logic [WIDTH-1:0] OUT_D,
    output logic             VALID_A,
    output logic             VALID_B,
    output logic             VALID_C,
    output logic             VALID_D,
    input  logic             READY_A,
    input  logic             READY_B,
    input  logic             READY_C,
    input  logic             READY_D,
    output logic             ERR
);

    logic [3:0]       sel_c;
    logic [3:0]       ready_c;
    logic [3:0]       push_c;
    logic [3:0]       slot_valid;
    logic [WIDTH-1:0] slot_data [NUM_SLOTS];
    sel_enc_t         enc_c;
    logic             accept_c;

    assign sel_c   = {SEL_D, SEL_C, SEL_B, SEL_A};
    assign ready_c = {READY_D, READY_C, READY_B, READY_A};
    assign enc_c   = prio_enc(sel_c);

    // A slot draining this cycle can take a new beat; no select means accept and drop.
    assign IN_READY = !enc_c.hit || !slot_valid[enc_c.idx] || ready_c[enc_c.idx];
    assign accept_c = IN_VALID && IN_READY;

    for (genvar g = 0; g < int'(NUM_SLOTS); g++) begin : g_slot
        assign push_c[g] = accept_c && enc_c.hit && (enc_c.idx == 2'(g));

        dist_slot #(.WIDTH(WIDTH)) u_slot (
            .clk_i   (CLK),
            .rst_i   (RESET),
            .push_i  (push_c[g]),
            .data_i  (IN),
            .ready_i (ready_c[g]),
            .valid_o (slot_valid[g]),
            .data_o  (slot_data[g])
        );
    end

    assign OUT_A   = slot_data[SLOT_A];
    assign OUT_B   = slot_data[SLOT_B];
    assign OUT_C   = slot_data[SLOT_C];
    assign OUT_D   = slot_data[SLOT_D];
    assign VALID_A = slot_valid[SLOT_A];
    assign VALID_B = slot_valid[SLOT_B];
    assign VALID_C = slot_valid[SLOT_C];
    assign VALID_D = slot_valid[SLOT_D];

`ifdef DISTRIBUTE1TO4_16_SELERR_EN
    logic err_q, err_d;

    // Sticky: any accepted beat whose select is not exactly one-hot.
    assign err_d = err_q || (accept_c && !$onehot(sel_c));

    always_ff @(posedge CLK) begin
        if (RESET) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_distribute1to4_16.sv
// Scoreboard bench for distribute1to4_16: directed scenarios then random traffic.
module tb_distribute1to4_16;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] IN = '0;
    logic        IN_VALID = 1'b0;
    logic        SEL_A = 1'b0, SEL_B = 1'b0, SEL_C = 1'b0, SEL_D = 1'b0;
    logic        READY_A = 1'b0, READY_B = 1'b0, READY_C = 1'b0, READY_D = 1'b0;
    logic        IN_READY, ERR;
    logic [15:0] OUT_A, OUT_B, OUT_C, OUT_D;
    logic        VALID_A, VALID_B, VALID_C, VALID_D;

    distribute1to4_16 dut (
        .CLK(CLK), .RESET(RESET), .IN(IN), .IN_VALID(IN_VALID),
        .SEL_A(SEL_A), .SEL_B(SEL_B), .SEL_C(SEL_C), .SEL_D(SEL_D),
        .IN_READY(IN_READY),
        .OUT_A(OUT_A), .OUT_B(OUT_B), .OUT_C(OUT_C), .OUT_D(OUT_D),
        .VALID_A(VALID_A), .VALID_B(VALID_B), .VALID_C(VALID_C), .VALID_D(VALID_D),
        .READY_A(READY_A), .READY_B(READY_B), .READY_C(READY_C), .READY_D(READY_D),
        .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: occupancy, last delivered data, pending beats per destination.
    logic        occ  [4];
    logic [15:0] last [4];
    logic [15:0] exp_q[4][$];
    logic        err_m;
    logic        model_known = 1'b0;

    logic [3:0]  dut_valid;
    logic [3:0]  dut_ready;
    logic [15:0] dut_out [4];
    assign dut_valid = {VALID_D, VALID_C, VALID_B, VALID_A};
    assign dut_ready = {READY_D, READY_C, READY_B, READY_A};
    assign dut_out[0] = OUT_A;
    assign dut_out[1] = OUT_B;
    assign dut_out[2] = OUT_C;
    assign dut_out[3] = OUT_D;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare against the reference, advance the reference.
    task automatic cycle(input logic rst, input logic vld, input logic [3:0] sel,
                         input logic [15:0] data, input logic [3:0] rdy);
        int  t;
        logic hit, exp_rdy, acc;
        RESET = rst; IN_VALID = vld; IN = data;
        {SEL_D, SEL_C, SEL_B, SEL_A} = sel;
        {READY_D, READY_C, READY_B, READY_A} = rdy;
        #1;
        hit = (sel != 4'b0);
        t = 3;
        for (int i = 3; i >= 0; i--) if (sel[i]) t = i;
        if (model_known) begin
            exp_rdy = !hit || !occ[t] || rdy[t];
            check("in_ready", 32'(IN_READY), 32'(exp_rdy));
            for (int x = 0; x < 4; x++) begin
                check($sformatf("valid_%0d", x), 32'(dut_valid[x]), 32'(occ[x]));
                check($sformatf("out_%0d", x), 32'(dut_out[x]), 32'(last[x]));
            end
            check("err", 32'(ERR), 32'(err_m));
        end else begin
            exp_rdy = 1'b0;
        end
        acc = vld && exp_rdy;
        if (rst) begin
            for (int x = 0; x < 4; x++) begin
                occ[x] = 1'b0; last[x] = '0; exp_q[x].delete();
            end
            err_m = 1'b0;
            model_known = 1'b1;
        end else if (model_known) begin
            for (int x = 0; x < 4; x++) begin
                if (acc && hit && t == x) begin
                    occ[x] = 1'b1; last[x] = data; exp_q[x].push_back(data);
                end else if (occ[x] && rdy[x]) begin
                    occ[x] = 1'b0;
                end
            end
`ifdef DISTRIBUTE1TO4_16_SELERR_EN
            if (acc && $countones(sel) != 1) err_m = 1'b1;
`endif
        end
        @(posedge CLK);
        #2;
    endtask

    // Monitor: every delivered beat must match the oldest beat routed to that slot.
    always @(negedge CLK) begin
        if (!RESET && model_known) begin
            for (int x = 0; x < 4; x++) begin
                if (dut_valid[x] === 1'b1 && dut_ready[x] === 1'b1) begin
                    if (exp_q[x].size() == 0) begin
                        check($sformatf("spurious_deliver_%0d", x), 32'(dut_valid[x]), 32'h0);
                    end else begin
                        check($sformatf("deliver_%0d", x), 32'(dut_out[x]),
                              32'(exp_q[x].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0]  sel, rdy;
        logic        vld;
        @(posedge CLK); #2;

        // Reset then idle
        cycle(1, 0, 4'b0001, 16'h0, 4'h0);
        cycle(1, 0, 4'b0001, 16'h0, 4'h0);
        cycle(0, 0, 4'b0001, 16'h0, 4'h0);
        check("idle_valids", 32'(dut_valid), 32'h0);

        // Basic route to C, then drain
        cycle(0, 1, 4'b0100, 16'h1234, 4'h0);
        check("route_valid", 32'(dut_valid), 32'h4);
        check("route_outc", 32'(OUT_C), 32'h1234);
        cycle(0, 0, 4'b0000, 16'h0, 4'b0100);
        check("drain_validc", 32'(VALID_C), 32'h0);
        check("drain_outc", 32'(OUT_C), 32'h1234);

        // Backpressure on B, then simultaneous pop and push
        cycle(0, 1, 4'b0010, 16'hAAAA, 4'h0);
        cycle(0, 1, 4'b0010, 16'hBBBB, 4'h0);
        check("bp_outb", 32'(OUT_B), 32'hAAAA);
        cycle(0, 1, 4'b0010, 16'hBBBB, 4'b0010);
        check("thru_outb", 32'(OUT_B), 32'hBBBB);
        check("thru_validb", 32'(VALID_B), 32'h1);
        cycle(0, 0, 4'b0000, 16'h0, 4'b0010);

        // Priority A over D, then no select
        cycle(0, 1, 4'b1001, 16'h00F0, 4'h0);
        check("prio_outa", 32'(OUT_A), 32'h00F0);
        check("prio_validd", 32'(VALID_D), 32'h0);
        cycle(0, 1, 4'b0000, 16'hDEAD, 4'h0);
        check("nosel_valids", 32'(dut_valid), 32'h1);

        // Reset mid-operation with A and D holding beats and a push to B
        cycle(0, 1, 4'b1000, 16'h1111, 4'h0);
        cycle(1, 1, 4'b0010, 16'h2222, 4'h0);
        check("rst_valids", 32'(dut_valid), 32'h0);
        check("rst_outd", 32'(OUT_D), 32'h0);

        // Random traffic, including multi/zero selects and retargeting under stall
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 9))
                0:       sel = 4'b0000;
                1:       sel = 4'($urandom);
                default: sel = 4'b0001 << $urandom_range(0, 3);
            endcase
            rdy = 4'($urandom) & 4'($urandom);
            vld = ($urandom_range(0, 3) != 0);
            cycle((n % 500) == 499, vld, sel, 16'($urandom), rdy);
        end

        // Drain everything; no routed beat may be left undelivered
        for (int n = 0; n < 4; n++) cycle(0, 0, 4'b0000, 16'h0, 4'hF);
        for (int x = 0; x < 4; x++)
            check($sformatf("leftover_%0d", x), 32'(exp_q[x].size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/distribute1to4_16.md
Name: distribute1to4_16

Overview:
- Write-side counterpart of the one-hot 4:1 read select: routes one 16-bit source beat to one of four destinations A/B/C/D using one-hot selects.
- Each destination has a registered single-entry holding slot with a valid/ready handshake.
- Sits between the datapath result bus and four consumers (register/latch targets), so producers stall cleanly while a destination is busy.

Parameters:
- WIDTH, 16, data width of input and of each destination slot.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN  input  WIDTH  source data.
- IN_VALID  input  1  source beat present.
- SEL_A  input  1  one-hot destination select A.
- SEL_B  input  1  one-hot destination select B.
- SEL_C  input  1  one-hot destination select C.
- SEL_D  input  1  one-hot destination select D.
- IN_READY  output  1  beat is accepted this cycle when IN_VALID and IN_READY are both high.
- OUT_A, OUT_B, OUT_C, OUT_D  output  WIDTH each  slot data, registered.
- VALID_A, VALID_B, VALID_C, VALID_D  output  1 each  slot holds an undelivered beat.
- READY_A, READY_B, READY_C, READY_D  input  1 each  consumer takes the slot beat when VALID_x and READY_x are both high.
- ERR  output  1  sticky select-error flag. Only meaningful with the optional feature.

Behaviour:
- Reset (RESET=1 at a clock edge): all VALID_x=0, all OUT_x=0, ERR=0. Reset overrides any push or pop in the same cycle. A mid-transfer beat is discarded.
- Destination resolution (combinational): priority A>B>C>D. The lowest-lettered asserted SEL wins; multiple selects are legal but resolve by priority. "Target" means the winning slot.
- IN_READY:
  - No SEL asserted: IN_READY=1. The beat is accepted and discarded; no slot changes.
  - Otherwise: IN_READY = !VALID_t | READY_t. A full slot being drained in the same cycle accepts a new beat, which gives one beat per clock of throughput.
  - IN_READY does not depend on IN_VALID.
- Push to target t: OUT_t<=IN and VALID_t<=1 at the next edge. Latency is 1 clock from acceptance to VALID_t.
- Pop of slot x: when VALID_x & READY_x, VALID_x<=0 unless slot x is pushed in the same cycle (push wins, VALID stays 1 with new data). OUT_x holds its last value after a pop.
- Non-target slots are unaffected by the input. Pops on all four slots may occur in the same cycle as any push.
- READY_x while VALID_x=0 has no effect.
- SEL changes while a beat is stalled (IN_VALID=1, IN_READY=0) retarget it. The producer is responsible for holding SEL stable.
- No combinational path from IN to OUT_x. The only combinational path to IN_READY is from SEL_x/READY_x.

Optional Feature:
- Macro: DISTRIBUTE1TO4_16_SELERR_EN.
- Defined: ERR is set to 1 at the edge after any accepted beat with zero SEL asserted or with more than one SEL asserted. ERR clears only on RESET.
- Not defined: ERR is tied to 0 and no checking logic is built. Routing behaviour is identical in both builds.

Decomposition:
- Shared package (nicnac16_pkg), which the read-select side also uses:
  - WORD_W=16.
  - Slot index constants SLOT_A=0, SLOT_B=1, SLOT_C=2, SLOT_D=3.
  - Priority-encode function one-hot SEL[3:0] -> {hit, index[1:0]}.
- One sub-module, dist_slot: a single-entry WIDTH-bit holding register with push/pop/valid, instantiated four times.
- The top level holds the priority encode, IN_READY mux and ERR logic.

Test Plan:
- Reset then idle: RESET=1 for 2 clocks -> all VALID_x=0, OUT_x=0, ERR=0, IN_READY=1 with SEL_A=1.
- Basic route: IN=16'h1234, SEL_C=1, IN_VALID=1 for 1 clock, READY_C=0 -> next cycle VALID_C=1, OUT_C=16'h1234, VALID_A/B/D=0. Then READY_C=1 for 1 clock -> VALID_C=0, OUT_C still 16'h1234.
- Backpressure and throughput:
  - Slot B full with 16'hAAAA and READY_B=0; drive IN=16'hBBBB with SEL_B -> IN_READY=0 and OUT_B stays 16'hAAAA.
  - Raise READY_B -> same cycle IN_READY=1; next cycle OUT_B=16'hBBBB and VALID_B=1 (simultaneous pop and push).
- Priority: SEL_A=SEL_D=1, IN=16'h00F0 -> OUT_A=16'h00F0, VALID_D stays 0. With the macro defined, ERR=1 next cycle and remains 1 until RESET.
- No select: IN_VALID=1, all SEL=0, IN=16'hDEAD -> IN_READY=1, no VALID_x rises. ERR=1 only with DISTRIBUTE1TO4_16_SELERR_EN defined, else 0.
- Reset mid-operation: slots A and D valid, assert RESET with a push to B in the same cycle -> all VALID_x=0, OUT_x=0 next cycle.
